// File: rtl/taxi_mac_pause_pkg.sv
// Shared constants and helpers for the MAC PAUSE/PFC receive path.
// Quanta are 16 bits wide, and the rate accumulator carries 8 fractional bits.
package taxi_mac_pause_pkg;

    localparam int QW  = 16;
    localparam int QFB = 8;

    localparam logic [15:0] LFC_OPCODE_DEFAULT = 16'h0001;
    localparam logic [15:0] PFC_OPCODE_DEFAULT = 16'h0101;
    localparam logic [15:0] ETHERTYPE_MAC_CTRL = 16'h8808;

    // The first parameter byte lands in bits [7:0], but on the wire that byte is the quanta MSB.
    function automatic logic [QW-1:0] quanta_bswap(input logic [QW-1:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/taxi_mac_pause_timer.sv
// One pause timer. Clear beats load, and load beats decrement.
// The decrement saturates at zero and is applied only while the MAC acknowledges the pause.
module taxi_mac_pause_timer
    import taxi_mac_pause_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [QW-1:0] load_val,
    input  logic          dec_en,
    input  logic [1:0]    dec,
    output logic          active,
    output logic [QW-1:0] count
);

    logic [QW-1:0] r_count;
    logic          r_active;
    logic [QW-1:0] w_count_next;
    logic [QW-1:0] w_dec;

    assign w_dec = {{(QW-2){1'b0}}, dec};

    // NOTE: the default assignment comes first so that every path assigns the signal and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (clr) begin
            w_count_next = '0;
        end else if (load) begin
            w_count_next = load_val;
        end else if (dec_en) begin
            w_count_next = (r_count >= w_dec) ? r_count - w_dec : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_active <= (w_count_next != '0);
        end
    end

    assign active = r_active;
    assign count  = r_count;

endmodule

// File: rtl/taxi_mac_pause_ctrl_rx.sv
// Receive-side LFC/PFC handling: decodes qualified MAC control frames and runs the pause timers.
// The timers drive pause requests toward the MAC transmit path.
module taxi_mac_pause_ctrl_rx
    import taxi_mac_pause_pkg::*;
#(
    parameter int   MCF_PARAMS_SIZE = 18,
    parameter logic PFC_EN          = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         mcf_valid,
    input  logic [15:0]                  mcf_opcode,
    input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

    input  logic [15:0]                  cfg_rx_lfc_opcode,
    input  logic                         cfg_rx_lfc_en,
    input  logic [15:0]                  cfg_rx_pfc_opcode,
    input  logic                         cfg_rx_pfc_en,
    input  logic [9:0]                   cfg_quanta_step,
    input  logic                         cfg_quanta_clk_en,

    output logic                         rx_lfc_req,
    input  logic                         rx_lfc_ack,
    output logic [7:0]                   rx_pfc_req,
    input  logic [7:0]                   rx_pfc_ack,

    output logic                         stat_rx_lfc_pkt,
    output logic                         stat_rx_lfc_xon,
    output logic                         stat_rx_lfc_xoff,
    output logic                         stat_rx_lfc_paused,
    output logic                         stat_rx_pfc_pkt,
    output logic [7:0]                   stat_rx_pfc_xon,
    output logic [7:0]                   stat_rx_pfc_xoff,
    output logic [7:0]                   stat_rx_pfc_paused
);

    if (MCF_PARAMS_SIZE < (PFC_EN ? 18 : 2)) begin : g_param_check
        $fatal(1, "MCF_PARAMS_SIZE too small for the selected PFC_EN setting");
    end

    logic [QFB-1:0] r_quanta_cnt;
    logic [1:0]     r_quanta_inc;
    logic [QFB+1:0] w_quanta_sum;

    // The sum wraps at 10 bits; its upper two bits are the whole quanta elapsed this cycle.
    assign w_quanta_sum = {2'b00, r_quanta_cnt} + cfg_quanta_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quanta_cnt <= '0;
            r_quanta_inc <= '0;
        end else if (cfg_quanta_clk_en) begin
            {r_quanta_inc, r_quanta_cnt} <= w_quanta_sum;
        end else begin
            r_quanta_inc <= '0;
        end
    end

    logic          w_lfc_accept;
    logic [QW-1:0] w_lfc_quanta;
    logic [QW-1:0] w_unused_lfc_count;
    logic          r_stat_lfc_pkt;
    logic          r_stat_lfc_xon;
    logic          r_stat_lfc_xoff;
    logic          w_unused_params;

    assign w_unused_params = ^mcf_params;
    assign w_lfc_accept    = mcf_valid && cfg_rx_lfc_en && (mcf_opcode == cfg_rx_lfc_opcode);
    assign w_lfc_quanta    = quanta_bswap(mcf_params[15:0]);

    taxi_mac_pause_timer u_lfc_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!cfg_rx_lfc_en),
        .load     (w_lfc_accept),
        .load_val (w_lfc_quanta),
        .dec_en   (rx_lfc_ack),
        .dec      (r_quanta_inc),
        .active   (rx_lfc_req),
        .count    (w_unused_lfc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_lfc_pkt  <= 1'b0;
            r_stat_lfc_xon  <= 1'b0;
            r_stat_lfc_xoff <= 1'b0;
        end else begin
            r_stat_lfc_pkt  <= w_lfc_accept;
            r_stat_lfc_xon  <= w_lfc_accept && (w_lfc_quanta == '0);
            r_stat_lfc_xoff <= w_lfc_accept && (w_lfc_quanta != '0);
        end
    end

    assign stat_rx_lfc_pkt    = r_stat_lfc_pkt;
    assign stat_rx_lfc_xon    = r_stat_lfc_xon;
    assign stat_rx_lfc_xoff   = r_stat_lfc_xoff;
    assign stat_rx_lfc_paused = rx_lfc_req & rx_lfc_ack;

    if (PFC_EN) begin : g_pfc
        logic          w_pfc_accept;
        logic [7:0]    w_pfc_class_en;
        logic [7:0]    w_pfc_load;
        logic [7:0]    w_pfc_zero;
        logic          r_stat_pfc_pkt;
        logic [7:0]    r_stat_pfc_xon;
        logic [7:0]    r_stat_pfc_xoff;

        assign w_pfc_accept   = mcf_valid && cfg_rx_pfc_en && (mcf_opcode == cfg_rx_pfc_opcode);
        assign w_pfc_class_en = mcf_params[15:8];
        assign w_pfc_load     = w_pfc_class_en & {8{w_pfc_accept}};

        for (genvar k = 0; k < 8; k++) begin : g_prio
            logic [QW-1:0] w_quanta;
            logic [QW-1:0] w_unused_count;

            assign w_quanta      = quanta_bswap(mcf_params[16*(k+1) +: 16]);
            assign w_pfc_zero[k] = (w_quanta == '0);

            taxi_mac_pause_timer u_timer (
                .clk      (clk),
                .rst      (rst),
                .clr      (!cfg_rx_pfc_en),
                .load     (w_pfc_load[k]),
                .load_val (w_quanta),
                .dec_en   (rx_pfc_ack[k]),
                .dec      (r_quanta_inc),
                .active   (rx_pfc_req[k]),
                .count    (w_unused_count)
            );
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stat_pfc_pkt  <= 1'b0;
                r_stat_pfc_xon  <= '0;
                r_stat_pfc_xoff <= '0;
            end else begin
                r_stat_pfc_pkt  <= w_pfc_accept;
                r_stat_pfc_xon  <= w_pfc_load & w_pfc_zero;
                r_stat_pfc_xoff <= w_pfc_load & ~w_pfc_zero;
            end
        end

        assign stat_rx_pfc_pkt    = r_stat_pfc_pkt;
        assign stat_rx_pfc_xon    = r_stat_pfc_xon;
        assign stat_rx_pfc_xoff   = r_stat_pfc_xoff;
        assign stat_rx_pfc_paused = rx_pfc_req & rx_pfc_ack;
    end else begin : g_no_pfc
        logic w_unused_pfc;

        assign w_unused_pfc       = ^{cfg_rx_pfc_opcode, cfg_rx_pfc_en, rx_pfc_ack};
        assign rx_pfc_req         = '0;
        assign stat_rx_pfc_pkt    = 1'b0;
        assign stat_rx_pfc_xon    = '0;
        assign stat_rx_pfc_xoff   = '0;
        assign stat_rx_pfc_paused = '0;
    end

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_rx.sv
// Bench for taxi_mac_pause_ctrl_rx: a decode table, directed timing sequences and randomized traffic.
// Every cycle is also compared against a cycle-level integer model of the pause rules.
module tb_taxi_mac_pause_ctrl_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic         mcf_valid;
    logic [15:0]  mcf_opcode;
    logic [143:0] mcf_params;
    logic [15:0]  cfg_rx_lfc_opcode;
    logic         cfg_rx_lfc_en;
    logic [15:0]  cfg_rx_pfc_opcode;
    logic         cfg_rx_pfc_en;
    logic [9:0]   cfg_quanta_step;
    logic         cfg_quanta_clk_en;
    logic         rx_lfc_req;
    logic         rx_lfc_ack;
    logic [7:0]   rx_pfc_req;
    logic [7:0]   rx_pfc_ack;
    logic         stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff, stat_rx_lfc_paused;
    logic         stat_rx_pfc_pkt;
    logic [7:0]   stat_rx_pfc_xon, stat_rx_pfc_xoff, stat_rx_pfc_paused;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    taxi_mac_pause_ctrl_rx #(.MCF_PARAMS_SIZE(18), .PFC_EN(1'b1)) dut (
        .clk                (clk),
        .rst                (rst),
        .mcf_valid          (mcf_valid),
        .mcf_opcode         (mcf_opcode),
        .mcf_params         (mcf_params),
        .cfg_rx_lfc_opcode  (cfg_rx_lfc_opcode),
        .cfg_rx_lfc_en      (cfg_rx_lfc_en),
        .cfg_rx_pfc_opcode  (cfg_rx_pfc_opcode),
        .cfg_rx_pfc_en      (cfg_rx_pfc_en),
        .cfg_quanta_step    (cfg_quanta_step),
        .cfg_quanta_clk_en  (cfg_quanta_clk_en),
        .rx_lfc_req         (rx_lfc_req),
        .rx_lfc_ack         (rx_lfc_ack),
        .rx_pfc_req         (rx_pfc_req),
        .rx_pfc_ack         (rx_pfc_ack),
        .stat_rx_lfc_pkt    (stat_rx_lfc_pkt),
        .stat_rx_lfc_xon    (stat_rx_lfc_xon),
        .stat_rx_lfc_xoff   (stat_rx_lfc_xoff),
        .stat_rx_lfc_paused (stat_rx_lfc_paused),
        .stat_rx_pfc_pkt    (stat_rx_pfc_pkt),
        .stat_rx_pfc_xon    (stat_rx_pfc_xon),
        .stat_rx_pfc_xoff   (stat_rx_pfc_xoff),
        .stat_rx_pfc_paused (stat_rx_pfc_paused)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Model state: integer timers and quanta bookkeeping, stepped once per clock.
    int       m_frac, m_inc, m_lfc;
    int       m_pfc[8];
    bit       m_lfc_pkt, m_lfc_xon, m_lfc_xoff, m_pfc_pkt;
    bit [7:0] m_pfc_xon, m_pfc_xoff;

    // Quanta value whose MSB is parameter byte idx and whose LSB is byte idx+1.
    function automatic int q_at(input int idx);
        return int'(mcf_params[8*idx +: 8]) * 256 + int'(mcf_params[8*idx+8 +: 8]);
    endfunction

    task automatic model_update();
        int dec, sum, q;
        bit lacc, pacc;
        bit [7:0] e;
        dec = m_inc;
        if (rst) begin
            m_frac = 0; m_inc = 0; m_lfc = 0;
            foreach (m_pfc[k]) m_pfc[k] = 0;
            m_lfc_pkt = 0; m_lfc_xon = 0; m_lfc_xoff = 0;
            m_pfc_pkt = 0; m_pfc_xon = 0; m_pfc_xoff = 0;
        end else begin
            sum = (m_frac + int'(cfg_quanta_step)) % 1024;
            if (cfg_quanta_clk_en) begin
                m_inc  = sum / 256;
                m_frac = sum % 256;
            end else begin
                m_inc = 0;
            end
            lacc = mcf_valid && cfg_rx_lfc_en && (mcf_opcode == cfg_rx_lfc_opcode);
            q = q_at(0);
            m_lfc_pkt  = lacc;
            m_lfc_xon  = lacc && (q == 0);
            m_lfc_xoff = lacc && (q != 0);
            if (!cfg_rx_lfc_en)   m_lfc = 0;
            else if (lacc)        m_lfc = q;
            else if (rx_lfc_ack)  m_lfc = (m_lfc > dec) ? m_lfc - dec : 0;

            pacc = mcf_valid && cfg_rx_pfc_en && (mcf_opcode == cfg_rx_pfc_opcode);
            e = mcf_params[15:8];
            m_pfc_pkt = pacc;
            for (int k = 0; k < 8; k++) begin
                q = q_at(2 * (k + 1));
                m_pfc_xon[k]  = pacc && e[k] && (q == 0);
                m_pfc_xoff[k] = pacc && e[k] && (q != 0);
                if (!cfg_rx_pfc_en)         m_pfc[k] = 0;
                else if (pacc && e[k])      m_pfc[k] = q;
                else if (rx_pfc_ack[k])     m_pfc[k] = (m_pfc[k] > dec) ? m_pfc[k] - dec : 0;
            end
        end
    endtask

    task automatic model_check();
        bit [7:0] preq;
        for (int k = 0; k < 8; k++) preq[k] = (m_pfc[k] != 0);
        check("lfc_req",  rx_lfc_req, m_lfc != 0);
        check("pfc_req",  rx_pfc_req, preq);
        check("lfc_stat", {stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff},
              {m_lfc_pkt, m_lfc_xon, m_lfc_xoff});
        check("pfc_stat", {stat_rx_pfc_pkt, stat_rx_pfc_xon, stat_rx_pfc_xoff},
              {m_pfc_pkt, m_pfc_xon, m_pfc_xoff});
        check("paused",   {stat_rx_lfc_paused, stat_rx_pfc_paused},
              {(m_lfc != 0) && rx_lfc_ack, preq & rx_pfc_ack});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [143:0] lfc_p(input logic [15:0] q);
        logic [143:0] p = '0;
        p[7:0]  = q[15:8];
        p[15:8] = q[7:0];
        return p;
    endfunction

    function automatic logic [143:0] pfc_p(input logic [7:0] e, input logic [15:0] dflt,
                                           input int ka, input logic [15:0] qa,
                                           input int kb, input logic [15:0] qb);
        logic [143:0] p = '0;
        p[15:8] = e;
        for (int k = 0; k < 8; k++) begin
            p[16*(k+1) +: 8]   = dflt[15:8];
            p[16*(k+1)+8 +: 8] = dflt[7:0];
        end
        p[16*(ka+1) +: 8]   = qa[15:8];
        p[16*(ka+1)+8 +: 8] = qa[7:0];
        p[16*(kb+1) +: 8]   = qb[15:8];
        p[16*(kb+1)+8 +: 8] = qb[7:0];
        return p;
    endfunction

    task automatic strobe(input logic [15:0] opc, input logic [143:0] p);
        mcf_valid  = 1'b1;
        mcf_opcode = opc;
        mcf_params = p;
        tick();
        mcf_valid  = 1'b0;
    endtask

    typedef struct {
        logic         rst;
        logic         lfc_en;
        logic         pfc_en;
        logic [15:0]  pfc_opc;
        logic         valid;
        logic [15:0]  opcode;
        logic [143:0] params;
        logic         exp_lfc_req;
        logic [7:0]   exp_pfc_req;
        logic [2:0]   exp_lfc_stat;
        logic [16:0]  exp_pfc_stat;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic le, input logic pe, input logic [15:0] popc,
                                input logic v, input logic [15:0] opc, input logic [143:0] p,
                                input logic elr, input logic [7:0] epr,
                                input logic [2:0] els, input logic [16:0] eps);
        vec_t t;
        t.rst = r; t.lfc_en = le; t.pfc_en = pe; t.pfc_opc = popc;
        t.valid = v; t.opcode = opc; t.params = p;
        t.exp_lfc_req = elr; t.exp_pfc_req = epr; t.exp_lfc_stat = els; t.exp_pfc_stat = eps;
        return t;
    endfunction

    vec_t tbl[11];

    initial begin
        int cnt;
        rst = 1'b1; mcf_valid = 1'b0; mcf_opcode = '0; mcf_params = '0;
        cfg_rx_lfc_opcode = 16'h0001; cfg_rx_pfc_opcode = 16'h0101;
        cfg_rx_lfc_en = 1'b1; cfg_rx_pfc_en = 1'b1;
        cfg_quanta_step = '0; cfg_quanta_clk_en = 1'b0;
        rx_lfc_ack = 1'b0; rx_pfc_ack = '0;
        run(2);
        rst = 1'b0;

        // Decode table: no quanta elapse, so timers only load, clear or hold.
        tbl[0]  = mk(1, 1, 1, 16'h0101, 0, 16'h0000, '0, 0, 8'h00, 3'b000, 17'h0);
        tbl[1]  = mk(0, 1, 1, 16'h0101, 1, 16'h0001, lfc_p(16'h0010), 1, 8'h00, 3'b101, 17'h0);
        tbl[2]  = mk(0, 1, 1, 16'h0101, 0, 16'h0001, '0, 1, 8'h00, 3'b000, 17'h0);
        tbl[3]  = mk(0, 1, 1, 16'h0101, 1, 16'h0002, lfc_p(16'h0000), 1, 8'h00, 3'b000, 17'h0);
        tbl[4]  = mk(0, 1, 1, 16'h0101, 1, 16'h0001, lfc_p(16'h0000), 0, 8'h00, 3'b110, 17'h0);
        tbl[5]  = mk(0, 1, 1, 16'h0101, 1, 16'h0101, pfc_p(8'h05, 16'hFFFF, 0, 16'd4, 2, 16'h0200),
                     0, 8'h05, 3'b000, {1'b1, 8'h00, 8'h05});
        tbl[6]  = mk(0, 1, 1, 16'h0101, 1, 16'h0101, pfc_p(8'h82, 16'hFFFF, 1, 16'd0, 7, 16'd5),
                     0, 8'h85, 3'b000, {1'b1, 8'h02, 8'h80});
        tbl[7]  = mk(0, 0, 1, 16'h0101, 1, 16'h0001, lfc_p(16'd5), 0, 8'h85, 3'b000, 17'h0);
        tbl[8]  = mk(0, 1, 0, 16'h0101, 1, 16'h0101, pfc_p(8'hFF, 16'd9, 0, 16'd9, 1, 16'd9),
                     0, 8'h00, 3'b000, 17'h0);
        tbl[9]  = mk(0, 1, 1, 16'h0001, 1, 16'h0001, pfc_p(8'h03, 16'h0, 0, 16'd2, 1, 16'd0),
                     1, 8'h01, 3'b101, {1'b1, 8'h02, 8'h01});
        tbl[10] = mk(1, 1, 1, 16'h0101, 0, 16'h0000, '0, 0, 8'h00, 3'b000, 17'h0);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; cfg_rx_lfc_en = tbl[i].lfc_en; cfg_rx_pfc_en = tbl[i].pfc_en;
            cfg_rx_pfc_opcode = tbl[i].pfc_opc;
            mcf_valid = tbl[i].valid; mcf_opcode = tbl[i].opcode; mcf_params = tbl[i].params;
            tick();
            check($sformatf("tbl%0d_lfc_req", i), rx_lfc_req, tbl[i].exp_lfc_req);
            check($sformatf("tbl%0d_pfc_req", i), rx_pfc_req, tbl[i].exp_pfc_req);
            check($sformatf("tbl%0d_lfc_stat", i), {stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff},
                  tbl[i].exp_lfc_stat);
            check($sformatf("tbl%0d_pfc_stat", i), {stat_rx_pfc_pkt, stat_rx_pfc_xon, stat_rx_pfc_xoff},
                  tbl[i].exp_pfc_stat);
        end
        rst = 1'b0; mcf_valid = 1'b0; cfg_rx_pfc_opcode = 16'h0101;

        // Whole-quantum rate: Q=16 holds req for exactly 16 cycles.
        cfg_quanta_step = 10'd256; cfg_quanta_clk_en = 1'b1; rx_lfc_ack = 1'b1;
        run(3);
        strobe(16'h0001, lfc_p(16'd16));
        check("lfc_first_req", rx_lfc_req, 1'b1);
        check("lfc_pkt_xoff", {stat_rx_lfc_pkt, stat_rx_lfc_xoff}, 2'b11);
        cnt = 1;
        for (int i = 0; i < 40 && rx_lfc_req; i++) begin
            tick();
            if (rx_lfc_req) cnt++;
        end
        check("lfc_len", cnt, 16);

        // XON arriving mid-pause ends it on the next cycle.
        strobe(16'h0001, lfc_p(16'd100));
        run(10);
        check("xon_pre_req", rx_lfc_req, 1'b1);
        strobe(16'h0001, lfc_p(16'd0));
        check("xon_req", rx_lfc_req, 1'b0);
        check("xon_stat", stat_rx_lfc_xon, 1'b1);
        cnt = 0;
        repeat (5) begin
            tick();
            if (stat_rx_lfc_xon) cnt++;
        end
        check("xon_once", cnt, 0);

        // With no ack the timer freezes; countdown starts once ack rises.
        rx_lfc_ack = 1'b0;
        strobe(16'h0001, lfc_p(16'd8));
        cnt = 0;
        repeat (20) begin
            tick();
            if (rx_lfc_req && !stat_rx_lfc_paused) cnt++;
        end
        check("ack_hold", cnt, 20);
        rx_lfc_ack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30 && rx_lfc_req; i++) begin
            tick();
            cnt++;
        end
        check("ack_fall", cnt, 8);

        // PFC subset: only enabled classes load.
        rx_pfc_ack = 8'hFF;
        strobe(16'h0101, pfc_p(8'h05, 16'hFFFF, 0, 16'd4, 2, 16'h0200));
        check("pfc_sub_req", rx_pfc_req, 8'h05);
        check("pfc_sub_xoff", stat_rx_pfc_xoff, 8'h05);
        check("pfc_sub_xon", stat_rx_pfc_xon, 8'h00);
        cnt = 0;
        for (int i = 0; i < 20 && rx_pfc_req[0]; i++) begin
            tick();
            cnt++;
        end
        check("pfc0_len", cnt, 4);
        check("pfc2_still", rx_pfc_req[2], 1'b1);
        cfg_rx_pfc_en = 1'b0;
        tick();
        check("pfc_disable", rx_pfc_req, 8'h00);
        cfg_rx_pfc_en = 1'b1;

        // Half a quantum per cycle roughly doubles the pause length.
        cfg_quanta_step = 10'd128;
        run(4);
        strobe(16'h0001, lfc_p(16'd10));
        cnt = 1;
        for (int i = 0; i < 60 && rx_lfc_req; i++) begin
            tick();
            if (rx_lfc_req) cnt++;
        end
        check("frac_len", (cnt >= 19 && cnt <= 21), 1'b1);

        // Reset during active pauses drops every request on the next cycle.
        cfg_quanta_step = 10'd256;
        strobe(16'h0001, lfc_p(16'd100));
        strobe(16'h0101, pfc_p(8'hFF, 16'd100, 0, 16'd100, 1, 16'd100));
        run(3);
        rst = 1'b1;
        tick();
        check("rst_lfc", rx_lfc_req, 1'b0);
        check("rst_pfc", rx_pfc_req, 8'h00);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) begin
                cfg_quanta_step   = 10'($urandom_range(0, 1023));
                cfg_rx_pfc_opcode = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'h0101;
            end
            rst               = ($urandom_range(0, 199) == 0);
            cfg_rx_lfc_en     = ($urandom_range(0, 31) != 0);
            cfg_rx_pfc_en     = ($urandom_range(0, 31) != 0);
            cfg_quanta_clk_en = ($urandom_range(0, 7) != 0);
            rx_lfc_ack        = ($urandom_range(0, 3) != 0);
            rx_pfc_ack        = 8'($urandom | $urandom);
            mcf_valid         = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       mcf_opcode = cfg_rx_lfc_opcode;
                1:       mcf_opcode = cfg_rx_pfc_opcode;
                2:       mcf_opcode = 16'h0002;
                default: mcf_opcode = 16'($urandom);
            endcase
            mcf_params = '0;
            mcf_params[7:0]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            mcf_params[15:8] = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                mcf_params[16*(k+1) +: 8]   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
                mcf_params[16*(k+1)+8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 60));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/taxi_mac_pause_ctrl_rx.md
Name: taxi_mac_pause_ctrl_rx

Overview:
Receive-side PAUSE (IEEE 802.3 annex 31B, LFC) and PFC (annex 31D) handling. Consumes MAC control frames already parsed and qualified upstream (destination and ethertype filtering are done before this block). Decodes pause quanta, runs one pause timer for LFC and one per PFC priority, and drives pause requests toward the MAC transmit path.
- Timers decrement only while the MAC acknowledges the pause.
- This block is the peer of the PFC/pause frame transmit controller.

Parameters:
- MCF_PARAMS_SIZE, 18, width of mcf_params in bytes. Elaboration $fatal if below (PFC_EN ? 18 : 2).
- PFC_EN, 1'b1, enables PFC decoding and the 8 per-priority timers. When 0, PFC outputs are tied to 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mcf_valid  in  1  single-cycle strobe, one per received control frame (no ready)
- mcf_opcode  in  16  MAC control opcode
- mcf_params  in  MCF_PARAMS_SIZE*8  frame parameters; byte 0 in bits [7:0], network order
- cfg_rx_lfc_opcode  in  16  LFC opcode match value (default 16'h0001)
- cfg_rx_lfc_en  in  1  LFC enable
- cfg_rx_pfc_opcode  in  16  PFC opcode match value (default 16'h0101)
- cfg_rx_pfc_en  in  1  PFC enable
- cfg_quanta_step  in  10  quanta per cycle, in units of 1/256 quanta
- cfg_quanta_clk_en  in  1  gates quanta accumulation
- rx_lfc_req  out  1  LFC pause request
- rx_lfc_ack  in  1  MAC TX has paused in response to LFC
- rx_pfc_req  out  8  per-priority pause request
- rx_pfc_ack  in  8  per-priority pause acknowledge
- stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff  out  1 each  single-cycle event pulses
- stat_rx_lfc_paused  out  1  rx_lfc_req & rx_lfc_ack
- stat_rx_pfc_pkt  out  1  single-cycle event pulse
- stat_rx_pfc_xon, stat_rx_pfc_xoff  out  8 each  single-cycle event pulses
- stat_rx_pfc_paused  out  8  rx_pfc_req & rx_pfc_ack

Behaviour:
- Quanta tick:
  - 8-bit fractional accumulator, quanta_cnt.
  - When cfg_quanta_clk_en is high: {quanta_inc, quanta_cnt} <= quanta_cnt + cfg_quanta_step, computed 10 bits wide.
  - When cfg_quanta_clk_en is low: quanta_inc <= 0 and the accumulator holds.
  - quanta_inc is 2 bits and registered; it is consumed by the timers one cycle later.
- LFC accept: mcf_valid & cfg_rx_lfc_en & (mcf_opcode == cfg_rx_lfc_opcode).
  - Q = {mcf_params[7:0], mcf_params[15:8]} (byte swap).
  - LFC timer <= Q.
- PFC accept: PFC_EN & mcf_valid & cfg_rx_pfc_en & (mcf_opcode == cfg_rx_pfc_opcode).
  - Class-enable vector E = mcf_params[15:8].
  - For each k with E[k]=1: Qk = {params[16(k+1) +: 8], params[16(k+1)+8 +: 8]}, and timer k <= Qk.
  - Timers with E[k]=0 continue unaffected.
- Both accept conditions may be true on the same strobe (equal opcodes configured); both then take effect.
- Timer update, each cycle, when no load occurs:
  - If ack is high: timer <= (timer >= inc) ? timer - inc : 0, where inc is quanta_inc_reg zero-extended to 16 bits.
  - If ack is low: timer holds.
- A load in the same cycle as a decrement wins; no decrement is applied that cycle.
- Q=0 (XON) clears the timer.
- Request outputs: rx_lfc_req = (lfc_timer != 0); rx_pfc_req[k] = (pfc_timer[k] != 0). Both come straight from registers.
- Latency: a frame strobed in cycle N makes the req change visible in cycle N+1. Stats pulse in cycle N+1.
- Stats:
  - *_pkt pulses on accept.
  - LFC: xon = (Q==0), xoff = (Q!=0).
  - PFC: xon[k] = E[k] & (Qk==0), xoff[k] = E[k] & (Qk!=0).
  - Unaccepted frames produce no stats and no timer change.
- Disable: while cfg_rx_lfc_en is low, the LFC timer is forced to 0 (req drops next cycle). The same applies to cfg_rx_pfc_en for all 8 PFC timers.
- Ack low with req high: timer frozen. Req stays high indefinitely until ack, a new frame, or disable.
- Ack high with req low: no effect.
- Reset: all timers, quanta_cnt, quanta_inc, reqs and stat pulses go to 0. Reset mid-pause drops req in the cycle after rst is sampled.

Decomposition:
- Package taxi_mac_pause_pkg holds:
  - QW=16, QFB=8;
  - localparams for the default LFC/PFC opcodes and for ethertype 16'h8808;
  - function quanta_bswap(16) -> 16.
- Sub-module taxi_mac_pause_timer, instantiated 1 + 8 times. Ports: clk, rst, clr, load, load_val[16], dec_en, dec[2]. Outputs: active, and count[16] for debug.

Test Plan:
- LFC pause: step=256, clk_en=1, ack=1, params[15:0]=16'h1000 (Q=16) -> rx_lfc_req high exactly 16 cycles starting N+1; stat_rx_lfc_pkt and stat_rx_lfc_xoff pulse at N+1.
- XON mid-pause: Q=100, then Q=0 frame 10 cycles later -> req falls the cycle after the XON strobe; stat_rx_lfc_xon pulses once.
- Ack gating: Q=8, ack=0 for 20 cycles, then ack=1 -> req held through the 20 cycles, then falls 8 cycles after ack rises; stat_rx_lfc_paused follows req&ack.
- PFC subset: E=8'h05, Q0=4, Q2=0x0200, other Qk=0xFFFF -> only rx_pfc_req[0] and [2] rise; [0] drops after 4 quanta; stat_rx_pfc_xoff=8'h05, stat_rx_pfc_xon=8'h00.
- Fractional rate: step=128 (half quanta per cycle), Q=10, ack=1 -> req high for 20 cycles (±1).
- Filtering and reset: opcode 16'h0002, or cfg_rx_lfc_en=0 -> no req, no stats. rst asserted during an active pause -> all reqs 0 the next cycle.
